// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default constants for button_debouncer
package debounce_pkg;
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_t;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: plain shift-register synchronizer for one asynchronous bit
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;
    always_ff @(posedge clk)
        if (reset) sr <= '0;
        else sr <= {sr[STAGES-2:0], d};
    assign q = sr[STAGES-1];
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizer plus stability-counter FSM turning a bouncing button into a clean level
// Optional long_press output is built when DEBOUNCE_LONG_PRESS_EN is defined.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef DEBOUNCE_LONG_PRESS_EN
    , parameter int LONG_PRESS_CYCLES = 100000000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_clean,
    output logic busy
`ifdef DEBOUNCE_LONG_PRESS_EN
    , output logic long_press
`endif
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    logic btn_sync;
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );
    // Any reversal while pending drops back to the old stable state, so the next attempt restarts from 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        case (state)
            STABLE_LOW: if (btn_sync) begin
                state_nxt = PEND_HIGH;
                cnt_nxt = CNT_W'(1);
            end
            PEND_HIGH: if (!btn_sync) begin
                state_nxt = STABLE_LOW;
                cnt_nxt = '0;
            end else if (cnt == CNT_MAX) begin
                state_nxt = STABLE_HIGH;
                cnt_nxt = '0;
            end else cnt_nxt = cnt + CNT_W'(1);
            STABLE_HIGH: if (!btn_sync) begin
                state_nxt = PEND_LOW;
                cnt_nxt = CNT_W'(1);
            end
            PEND_LOW: if (btn_sync) begin
                state_nxt = STABLE_HIGH;
                cnt_nxt = '0;
            end else if (cnt == CNT_MAX) begin
                state_nxt = STABLE_LOW;
                cnt_nxt = '0;
            end else cnt_nxt = cnt + CNT_W'(1);
            default: begin
                state_nxt = STABLE_LOW;
                cnt_nxt = '0;
            end
        endcase
    end
    always_ff @(posedge clk)
        if (reset) begin
            state <= STABLE_LOW;
            cnt <= '0;
            btn_clean <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            btn_clean <= state_nxt == STABLE_HIGH || state_nxt == PEND_LOW;
            busy <= state_nxt == PEND_HIGH || state_nxt == PEND_LOW;
        end
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    assign hold_nxt = state != STABLE_HIGH ? '0 : hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + HOLD_W'(1);
    // Looking at state_nxt lets long_press drop on the same edge the FSM enters PEND_LOW.
    always_ff @(posedge clk)
        if (reset) begin
            hold_cnt <= '0;
            long_press <= 1'b0;
        end else begin
            hold_cnt <= hold_nxt;
            long_press <= state_nxt == STABLE_HIGH && hold_nxt == HOLD_MAX;
        end
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: table-driven and hand-sequenced scoreboard checks of button_debouncer
module tb_button_debouncer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b1;
    logic btn_clean, busy, long_press;
    logic prev_clean = 1'b0;
    int rises = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(8)
`ifdef DEBOUNCE_LONG_PRESS_EN
        , .LONG_PRESS_CYCLES(20)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .btn_clean (btn_clean),
        .busy      (busy)
`ifdef DEBOUNCE_LONG_PRESS_EN
        , .long_press(long_press)
`endif
    );
`ifndef DEBOUNCE_LONG_PRESS_EN
    assign long_press = 1'b0;
`endif

    // Stand-in for the downstream rising-edge detector.
    always @(posedge clk) begin
        if (btn_clean && !prev_clean) rises <= rises + 1;
        prev_clean <= btn_clean;
    end

    typedef struct {
        string name;
        int    exp;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        string name;
        bit    btn;
        int    cycles;
        bit    clean;
        bit    busy;
    } vec_t;

    function automatic int outs();
        return int'({long_press, busy, btn_clean});
    endfunction

    task automatic push(input string name, input int exp);
        sb.push_back('{name, exp});
    endtask

    task automatic pop_chk(input int act);
        sb_t s;
        s = sb.pop_front();
        checks++;
        if (act !== s.exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", s.name, act, s.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge index (0 = first edge after the call) at which the selected output reaches target.
    task automatic wait_sig(input bit sel, input bit target, input int exp, input string name);
        int n;
        push(name, exp);
        for (n = 0; n < 40; n++) begin
            tick();
            if ((sel ? long_press : btn_clean) === target) break;
        end
        pop_chk(n);
    endtask

    vec_t vt[16];

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{"press_e1",    1, 2, 0, 0};
        vt[1]  = '{"press_e2",    1, 1, 0, 1};
        vt[2]  = '{"press_e9",    1, 7, 0, 1};
        vt[3]  = '{"press_e10",   1, 1, 1, 0};
        vt[4]  = '{"held_high",   1, 5, 1, 0};
        vt[5]  = '{"rel_e2",      0, 3, 1, 1};
        vt[6]  = '{"rel_e9",      0, 7, 1, 1};
        vt[7]  = '{"rel_e10",     0, 1, 0, 0};
        vt[8]  = '{"held_low",    0, 4, 0, 0};
        vt[9]  = '{"g7_pending",  1, 7, 0, 1};
        vt[10] = '{"g7_rejected", 0, 3, 0, 0};
        vt[11] = '{"g7_quiet",    0, 3, 0, 0};
        vt[12] = '{"g9_pending",  1, 9, 0, 1};
        vt[13] = '{"g9_toggled",  0, 2, 1, 0};
        vt[14] = '{"g9_pend_low", 0, 8, 1, 1};
        vt[15] = '{"g9_low",      0, 1, 0, 0};

        repeat (3) begin
            tick();
            push("in_reset", 0);
            pop_chk(outs());
        end
        reset = 1'b0;
        wait_sig(0, 1, 10, "reset_release_rise");
        btn_in = 1'b0;
        wait_sig(0, 0, 10, "first_fall");

        foreach (vt[i]) begin
            btn_in = vt[i].btn;
            repeat (vt[i].cycles) tick();
            push(vt[i].name, int'({1'b0, vt[i].busy, vt[i].clean}));
            pop_chk(outs());
        end

        begin : bounce
            int r0;
            r0 = rises;
            for (int k = 0; k < 4; k++) begin
                btn_in = (k % 2 == 0);
                repeat (3) tick();
            end
            push("bounce_no_rise", 0);
            pop_chk(rises - r0);
            push("bounce_low", 0);
            pop_chk(int'(btn_clean));
            btn_in = 1'b1;
            wait_sig(0, 1, 10, "bounce_settle_rise");
            repeat (5) tick();
            push("bounce_one_pulse", 1);
            pop_chk(rises - r0);
            btn_in = 1'b0;
            wait_sig(0, 0, 10, "bounce_fall");
        end

        btn_in = 1'b1;
        repeat (7) tick();
        push("mid_pending", 2);
        pop_chk(outs());
        reset = 1'b1;
        tick();
        push("mid_reset", 0);
        pop_chk(outs());
        reset = 1'b0;
        wait_sig(0, 1, 10, "mid_release_rise");
        btn_in = 1'b0;
        wait_sig(0, 0, 10, "mid_fall");

`ifdef DEBOUNCE_LONG_PRESS_EN
        btn_in = 1'b1;
        wait_sig(0, 1, 10, "lp_clean_rise");
        repeat (19) tick();
        push("lp_before", 1);
        pop_chk(outs());
        tick();
        push("lp_asserted", 5);
        pop_chk(outs());
        btn_in = 1'b0;
        repeat (2) tick();
        push("lp_still_high", 5);
        pop_chk(outs());
        tick();
        push("lp_clear_pend_low", 3);
        pop_chk(outs());
        repeat (8) tick();
        push("lp_release_low", 0);
        pop_chk(outs());
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
